// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: program memory and datapath control bus between sequencer and accumulator datapath
interface alu_sequencer_if #(parameter int PC_W = 12);
  logic [PC_W-1:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] operand;
  logic [2:0] alu_sel;
  logic bus_en;
  logic accu_en;
  logic out_en;
  logic [1:0] alu_flags;
  modport master (
    output prog_addr, operand, alu_sel, bus_en, accu_en, out_en,
    input  prog_data, alu_flags
  );
  modport slave (
    input  prog_addr, operand, alu_sel, bus_en, accu_en, out_en,
    output prog_data, alu_flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for the 4-bit accumulator datapath
module alu_sequencer #(parameter int PC_W = 12) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  alu_sequencer_if.master bus,
  output logic carry,
  output logic zero,
  output logic busy,
  output logic halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, FETCH2, JUMP, HALTED} state_t;
  state_t state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [7:0] ir;
  logic [3:0] op, dop;
  logic [11:0] tgt;
  logic ex, alu_op, taken;
  always_comb begin
    op = ir[7:4];
    dop = bus.prog_data[7:4];
    tgt = {ir[3:0], bus.prog_data};
    ex = state == EXEC;
    alu_op = op >= 4'h1 && op <= 4'h4;
    taken = op == 4'h6 || (op == 4'h7 && carry) || (op == 4'h8 && zero) || (op == 4'h9 && !zero);
    state_nxt = state;
    pc_nxt = pc;
    case (state)
      IDLE: state_nxt = start ? FETCH : IDLE;
      FETCH: state_nxt = DECODE;
      DECODE: begin
        pc_nxt = pc + PC_W'(1);
        state_nxt = dop == 4'hF ? HALTED : (dop >= 4'h6 && dop <= 4'h9) ? FETCH2 : EXEC;
      end
      EXEC: state_nxt = FETCH;
      FETCH2: state_nxt = JUMP;
      JUMP: begin
        // not-taken jumps step past the target byte
        pc_nxt = taken ? tgt[PC_W-1:0] : pc + PC_W'(1);
        state_nxt = FETCH;
      end
      default: state_nxt = state;
    endcase
    bus.operand = ex ? ir[3:0] : 4'h0;
    bus.alu_sel = !ex ? 3'd0 : op == 4'h1 ? 3'd2 : op == 4'h2 ? 3'd3 : op == 4'h3 ? 3'd1 : op == 4'h4 ? 3'd4 : 3'd0;
    bus.bus_en = ex && alu_op;
    bus.accu_en = ex && alu_op && op != 4'h3;
    bus.out_en = ex && op == 4'h5;
    busy = state != IDLE && state != HALTED;
    halted = state == HALTED;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      bus.prog_addr <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      if (state == DECODE) ir <= bus.prog_data;
      if (state_nxt == FETCH || state_nxt == FETCH2) bus.prog_addr <= pc_nxt;
      if (ex && alu_op) {zero, carry} <= bus.alu_flags;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors plus jump/halt/reset/wrap sequences with a datapath scoreboard
module tb_alu_sequencer;
  typedef logic [9:0] dp_t;
  typedef struct {logic [7:0] i0, i1, i2; logic [3:0] acc; logic c, z;} vec_t;
  logic clk = 0;
  logic rst12 = 1, start12 = 0, carry12, zero12, busy12, halted12;
  logic rst8 = 1, start8 = 0, carry8, zero8, busy8, halted8;
  logic [7:0] mem12 [4096];
  logic [7:0] mem8 [256];
  logic [3:0] acc12, acc8;
  logic [4:0] r12, r8;
  logic [7:0] last8 = 0;
  logic [7:0] log8 [$];
  logic [7:0] e8 [6];
  dp_t q12 [$], q8 [$];
  vec_t tv [8];
  int checks = 0, errors = 0;
  alu_sequencer_if #(.PC_W(12)) b12 ();
  alu_sequencer_if #(.PC_W(8)) b8 ();
  alu_sequencer #(.PC_W(12)) u12 (.clk(clk), .reset(rst12), .start(start12), .bus(b12),
    .carry(carry12), .zero(zero12), .busy(busy12), .halted(halted12));
  alu_sequencer #(.PC_W(8)) u8 (.clk(clk), .reset(rst8), .start(start8), .bus(b8),
    .carry(carry8), .zero(zero8), .busy(busy8), .halted(halted8));
  always #5 clk = ~clk;
  function automatic logic [4:0] alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0: alu = {1'b0, a};
      3'd1: alu = {a < b, a - b};
      3'd2: alu = {1'b0, b};
      3'd3: alu = {1'b0, a} + {1'b0, b};
      3'd4: alu = {1'b0, ~(a & b)};
      default: alu = '0;
    endcase
  endfunction
  function automatic dp_t dp_exp(input logic [7:0] b);
    case (b[7:4])
      4'h1: dp_exp = {3'd2, 3'b110, b[3:0]};
      4'h2: dp_exp = {3'd3, 3'b110, b[3:0]};
      4'h3: dp_exp = {3'd1, 3'b100, b[3:0]};
      4'h4: dp_exp = {3'd4, 3'b110, b[3:0]};
      4'h5: dp_exp = {3'd0, 3'b001, b[3:0]};
      default: dp_exp = '0;
    endcase
  endfunction
  assign r12 = alu(b12.alu_sel, acc12, b12.operand);
  assign r8 = alu(b8.alu_sel, acc8, b8.operand);
  assign b12.alu_flags = {r12[3:0] == 4'h0, r12[4]};
  assign b8.alu_flags = {r8[3:0] == 4'h0, r8[4]};
  always @(posedge clk) begin
    b12.prog_data <= mem12[b12.prog_addr];
    b8.prog_data <= mem8[b8.prog_addr];
    acc12 <= rst12 ? 4'h0 : b12.accu_en ? r12[3:0] : acc12;
    acc8 <= rst8 ? 4'h0 : b8.accu_en ? r8[3:0] : acc8;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b12.bus_en || b12.accu_en || b12.out_en) begin
      if (q12.size() == 0) chk("dp12_unexpected", 32'({b12.alu_sel, b12.bus_en, b12.accu_en, b12.out_en, b12.operand}), 0);
      else chk("dp12", 32'({b12.alu_sel, b12.bus_en, b12.accu_en, b12.out_en, b12.operand}), 32'(q12.pop_front()));
    end
    if (b8.bus_en || b8.accu_en || b8.out_en) begin
      if (q8.size() == 0) chk("dp8_unexpected", 32'({b8.alu_sel, b8.bus_en, b8.accu_en, b8.out_en, b8.operand}), 0);
      else chk("dp8", 32'({b8.alu_sel, b8.bus_en, b8.accu_en, b8.out_en, b8.operand}), 32'(q8.pop_front()));
    end
    if (!rst8 && b8.prog_addr !== last8) begin
      log8.push_back(b8.prog_addr);
      last8 = b8.prog_addr;
    end
  end
  task automatic push12(input logic [7:0] b);
    dp_t d;
    d = dp_exp(b);
    if (d[6:4] != 3'b000) q12.push_back(d);
  endtask
  task automatic push8(input logic [7:0] b);
    dp_t d;
    d = dp_exp(b);
    if (d[6:4] != 3'b000) q8.push_back(d);
  endtask
  task automatic reset12;
    rst12 = 1;
    repeat (2) @(negedge clk);
    rst12 = 0;
  endtask
  task automatic clear12;
    for (int i = 0; i < 4096; i++) mem12[i] = 8'hF0;
  endtask
  task automatic pulse12;
    start12 = 1;
    @(negedge clk);
    start12 = 0;
  endtask
  task automatic wait_halt(input bit w8);
    int n;
    n = 0;
    while (!(w8 ? halted8 : halted12) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(w8 ? "halt8_timeout" : "halt12_timeout", 32'(w8 ? halted8 : halted12), 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int oc;
    tv[0] = '{8'h15, 8'h23, 8'h50, 4'h8, 1'b0, 1'b0};
    tv[1] = '{8'h1F, 8'h21, 8'h00, 4'h0, 1'b1, 1'b1};
    tv[2] = '{8'h17, 8'h37, 8'h50, 4'h7, 1'b0, 1'b1};
    tv[3] = '{8'h13, 8'h35, 8'h00, 4'h3, 1'b1, 1'b0};
    tv[4] = '{8'h1C, 8'h4A, 8'h00, 4'h7, 1'b0, 1'b0};
    tv[5] = '{8'h1F, 8'h4F, 8'hA5, 4'h0, 1'b0, 1'b1};
    tv[6] = '{8'h10, 8'h2F, 8'h50, 4'hF, 1'b0, 1'b0};
    tv[7] = '{8'h1E, 8'h23, 8'h50, 4'h1, 1'b1, 1'b0};
    e8 = '{8'h01, 8'h02, 8'hFF, 8'h00, 8'h40, 8'h41};
    for (int i = 0; i < 256; i++) mem8[i] = 8'hF0;
    clear12();
    reset12();
    chk("rst_prog_addr", 32'(b12.prog_addr), 0);
    chk("rst_busy_halted", 32'({busy12, halted12}), 0);
    chk("rst_flags", 32'({carry12, zero12}), 0);
    chk("rst_dp", 32'({b12.alu_sel, b12.bus_en, b12.accu_en, b12.out_en, b12.operand}), 0);
    // HALT: terminal, start ignored, reset back to IDLE
    pulse12();
    wait_halt(0);
    chk("halt_busy", 32'(busy12), 0);
    pulse12();
    repeat (3) @(negedge clk);
    chk("halt_sticky", 32'({halted12, busy12}), 32'b10);
    chk("halt_addr", 32'(b12.prog_addr), 0);
    reset12();
    chk("halt_reset", 32'({halted12, busy12, b12.prog_addr}), 0);
    // LIT 5, ADDI 3, OUT cycle timing
    mem12[0] = 8'h15; mem12[1] = 8'h23; mem12[2] = 8'h50;
    push12(8'h15); push12(8'h23); push12(8'h50);
    start12 = 1;
    @(negedge clk);
    start12 = 0;
    chk("c1_busy", 32'(busy12), 1);
    chk("c1_prog_addr", 32'(b12.prog_addr), 0);
    oc = 0;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (b12.out_en && oc == 0) begin
        oc = n;
        chk("out_accu", 32'(acc12), 8);
        chk("out_flags", 32'({carry12, zero12}), 0);
      end
    end
    chk("out_cycle", 32'(oc), 9);
    wait_halt(0);
    for (int i = 0; i < 8; i++) begin
      clear12();
      reset12();
      mem12[0] = tv[i].i0; mem12[1] = tv[i].i1; mem12[2] = tv[i].i2;
      push12(tv[i].i0); push12(tv[i].i1); push12(tv[i].i2);
      pulse12();
      wait_halt(0);
      chk($sformatf("vec%0d_accu", i), 32'(acc12), 32'(tv[i].acc));
      chk($sformatf("vec%0d_flags", i), 32'({carry12, zero12}), 32'({tv[i].c, tv[i].z}));
      chk($sformatf("vec%0d_addr", i), 32'(b12.prog_addr), 3);
    end
    // CMPI equal then JZ to 0x123
    clear12();
    reset12();
    mem12[0] = 8'h17; mem12[1] = 8'h37; mem12[2] = 8'h81; mem12[3] = 8'h23;
    push12(8'h17); push12(8'h37);
    pulse12();
    wait_halt(0);
    chk("jz_addr", 32'(b12.prog_addr), 32'h123);
    chk("jz_accu", 32'(acc12), 7);
    chk("jz_flags", 32'({carry12, zero12}), 32'b01);
    // JC taken to 0x010, JNZ not taken skips its target byte
    clear12();
    reset12();
    mem12[0] = 8'h1F; mem12[1] = 8'h21; mem12[2] = 8'h70; mem12[3] = 8'h10;
    mem12[16] = 8'h91; mem12[17] = 8'h55; mem12[12'h155] = 8'h1A;
    push12(8'h1F); push12(8'h21);
    pulse12();
    wait_halt(0);
    chk("jnz_addr", 32'(b12.prog_addr), 32'h012);
    chk("jnz_flags", 32'({carry12, zero12}), 32'b11);
    // reset during EXEC of ADDI
    clear12();
    reset12();
    mem12[0] = 8'h1F; mem12[1] = 8'h21;
    push12(8'h1F); push12(8'h21);
    pulse12();
    repeat (5) @(negedge clk);
    chk("rexec_in_exec", 32'({b12.alu_sel, b12.bus_en, b12.accu_en}), 32'b01111);
    rst12 = 1;
    @(negedge clk);
    chk("rexec_dp", 32'({b12.bus_en, b12.accu_en, b12.out_en, b12.alu_sel, b12.operand}), 0);
    chk("rexec_flags", 32'({carry12, zero12}), 0);
    chk("rexec_busy", 32'(busy12), 0);
    rst12 = 0;
    // PC_W=8: JMP at 0xFF with its target byte wrapped to 0x00
    mem8[0] = 8'h40; mem8[1] = 8'h60; mem8[2] = 8'hFF; mem8[255] = 8'h60;
    mem8[8'h40] = 8'h1C;
    push8(8'h40); push8(8'h1C);
    rst8 = 1;
    repeat (2) @(negedge clk);
    rst8 = 0;
    log8.delete();
    start8 = 1;
    @(negedge clk);
    start8 = 0;
    wait_halt(1);
    chk("wrap_log_len", 32'(log8.size()), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("wrap_fetch%0d", i), 32'(i < log8.size() ? log8[i] : 8'hXX), 32'(e8[i]));
    chk("wrap_accu", 32'(acc8), 32'hC);
    chk("sb12_empty", 32'(q12.size()), 0);
    chk("sb8_empty", 32'(q8.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
